// File: rtl/udma_eth_tx_desc_sched.sv
// Descriptor scheduler for the Ethernet uDMA TX channel.
// Queues (start address, size) descriptors and launches them one at a time.
// A launch is a single-cycle ch_en_o pulse. Each transfer must finish before the next one starts.
module udma_eth_tx_desc_sched #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      sched_en_i,
  input  logic                      flush_i,
  input  logic                      desc_valid_i,
  output logic                      desc_ready_o,
  input  logic [L2_AWIDTH_NOAL-1:0] desc_addr_i,
  input  logic [TRANS_SIZE-1:0]     desc_size_i,
  output logic [L2_AWIDTH_NOAL-1:0] ch_startaddr_o,
  output logic [TRANS_SIZE-1:0]     ch_size_o,
  output logic                      ch_continuous_o,
  output logic                      ch_en_o,
  input  logic                      ch_en_i,
  input  logic                      ch_pending_i,
  output logic                      busy_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  logic [L2_AWIDTH_NOAL-1:0] addr_mem [DEPTH];
  logic [TRANS_SIZE-1:0]     size_mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [LVL_W-1:0]          count;
  logic [CNT_W-1:0]          to_cnt;
  state_t                    state;

  logic push_hs;
  logic push_zero;
  logic push_wr;
  logic launch;
  logic ch_ack;
  logic timeout_hit;

  // Handshake, launch and timeout decode.
  // A zero-size descriptor completes the handshake, but it is never written to the queue.
  always_comb begin
    desc_ready_o = (count != LVL_FULL) && !flush_i;
    push_hs      = desc_valid_i && desc_ready_o;
    push_zero    = push_hs && (desc_size_i == '0);
    push_wr      = push_hs && !push_zero;
    ch_ack       = ch_en_i || ch_pending_i;
    launch       = (state == IDLE) && sched_en_i && (count != '0) && !flush_i && !ch_ack;
    timeout_hit  = (state == WAIT_ACK) && !ch_ack && (to_cnt == CNT_LAST);
  end

  assign busy_o          = (state != IDLE);
  assign level_o         = count;
  assign ch_continuous_o = 1'b0;

  // Descriptor storage: data only, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_wr) begin
      addr_mem[wr_ptr] <= desc_addr_i;
      size_mem[wr_ptr] <= desc_size_i;
    end
  end

  // Queue pointers and level.
  // The pointers wrap naturally because DEPTH is a power of 2.
  // A flush wins over any pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_wr) wr_ptr <= wr_ptr + 1'b1;
      if (launch)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_wr, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Launch FSM with registered channel config, launch pulse, done and error pulses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= IDLE;
      to_cnt         <= '0;
      ch_en_o        <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      ch_startaddr_o <= '0;
      ch_size_o      <= '0;
    end else begin
      ch_en_o <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= push_zero || timeout_hit;
      case (state)
        IDLE: begin
          if (launch) begin
            ch_startaddr_o <= addr_mem[rd_ptr];
            ch_size_o      <= size_mem[rd_ptr];
            ch_en_o        <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          to_cnt <= '0;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ch_ack) begin
            state <= WAIT_DONE;
          end else if (to_cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!ch_ack) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/udma_eth_tx_desc_sched.md
Name: udma_eth_tx_desc_sched

Overview:
Descriptor scheduler for the Ethernet-frame uDMA TX channel. Software or a frame builder pushes (start address, size) descriptors into a small queue. The block launches them back-to-back on the channel by driving the channel's startaddr/size/enable configuration signals, and waits for each transfer to finish before launching the next. It sits between the TX configuration register interface and the uDMA channel, and reports per-frame completion, errors and queue level.

Parameters:
L2_AWIDTH_NOAL, 12, width of L2 word-aligned start address
TRANS_SIZE, 16, width of transfer size field
DEPTH, 4, descriptor queue depth (power of 2, >=2)
TIMEOUT, 255, max cycles to wait for channel to acknowledge launch (>=1)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
sched_en_i  in  1  1 = launching of queued descriptors allowed
flush_i  in  1  synchronous queue clear
desc_valid_i  in  1  descriptor push request
desc_ready_o  out  1  queue can accept descriptor
desc_addr_i  in  L2_AWIDTH_NOAL  frame start address
desc_size_i  in  TRANS_SIZE  frame size in bytes
ch_startaddr_o  out  L2_AWIDTH_NOAL  to channel start address
ch_size_o  out  TRANS_SIZE  to channel size
ch_continuous_o  out  1  tied 0 (single-shot transfers)
ch_en_o  out  1  one-cycle channel launch pulse
ch_en_i  in  1  channel active
ch_pending_i  in  1  channel has pending transfer
busy_o  out  1  state != IDLE
level_o  out  $clog2(DEPTH)+1  descriptors queued (excluding in-flight)
done_o  out  1  one-cycle pulse per completed frame
err_o  out  1  one-cycle pulse: zero-size push or launch timeout

Behaviour:
- Reset: queue empty, state IDLE. All outputs 0, except desc_ready_o=1 once rstn_i is high.
- Push: handshake when desc_valid_i & desc_ready_o.
  - desc_ready_o = !full & !flush_i, registered-free (combinational from count/flush).
  - Push while full: not accepted. A pop in the same cycle does not free a slot until the next cycle.
  - desc_size_i==0: accepted, discarded, err_o pulses in next cycle; level unchanged.
- Queue: circular FIFO with wrapping rd/wr pointers. Push and pop in the same cycle: level unchanged.
- flush_i: level->0 and pointers reset at the next edge. A pop in the same cycle is suppressed. An in-flight transfer is not aborted.
- FSM:
  - IDLE: if sched_en_i & level!=0 & !flush_i & !ch_en_i & !ch_pending_i, then at the edge: pop head into ch_startaddr_o/ch_size_o regs, go to LAUNCH.
  - LAUNCH: ch_en_o=1 for exactly this cycle. Clear timeout counter, go to WAIT_ACK.
  - WAIT_ACK: if ch_en_i | ch_pending_i, go to WAIT_DONE. Otherwise increment the counter. When counter reaches TIMEOUT, pulse err_o and go to IDLE; the descriptor is dropped and done_o is not pulsed.
  - WAIT_DONE: when !ch_en_i & !ch_pending_i, pulse done_o (registered, the cycle after detection) and go to IDLE.
- Latency: launch condition true in cycle T gives ch_en_o high in T+1. Minimum gap between consecutive ch_en_o pulses is 4 cycles.
- ch_startaddr_o/ch_size_o hold their last launched values until the next pop.
- sched_en_i low: no new launch. A transfer in progress completes normally.
- Simultaneous err sources (zero-size push and timeout in the same cycle) give a single err_o pulse.
- Reset mid-transfer: immediate return to reset values. The queue is lost and no done_o is generated.

Test Plan:
- Push (0x100,64), sched_en_i=1, channel asserts ch_en_i 2 cycles after ch_en_o and drops it 10 cycles later. Required: ch_en_o in cycle T+1 with addr 0x100, size 64; done_o one pulse; level_o 1->0.
- Push 4 descriptors with sched_en_i=0. Required: desc_ready_o=0 at level 4 and a 5th push is refused. Set sched_en_i=1: four launches in FIFO order, with ch_startaddr_o matching each push and four done_o pulses.
- Push size 0. Required: err_o one pulse, level_o stays 0, no ch_en_o.
- Channel never acknowledges with TIMEOUT=8. Required: err_o 9 cycles after the ch_en_o cycle, return to IDLE, next descriptor launched.
- 3 queued descriptors, first in WAIT_DONE, pulse flush_i. Required: level_o=0 next cycle, first transfer still yields done_o, no further launches.
- Push and pop in the same cycle at level 2 and pointer wrap after 2*DEPTH pushes. Required: level_o stays consistent and data order is preserved.
